// File: rtl/dmem_pkg.sv
// Shared state encoding and parameter defaults for the data-memory responder.
// The wait counter is sized for at most 15 extra cycles.
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } dmem_state_e;

   localparam int          DEF_DEPTH_WORDS = 1024;
   localparam logic [31:0] DEF_BASE_ADDR   = 32'h0000_0000;
   localparam int          DEF_WAIT_CYCLES = 1;
   localparam int          WAIT_CNT_W      = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port word array with per-byte write enables and a registered read port.
// Read data changes only on an enabled read, so it holds while a response waits.
module dmem_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             en_i,
   input  logic             we_i,
   input  logic [3:0]       be_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [31:0]      wdata_i,
   output logic [31:0]      rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            for (int b = 0; b < 4; b++) begin
               if (be_i[b]) begin
                  mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
               end
            end
         end else begin
            rdata_q <= mem_q[idx_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave: one request at a time, response WAIT_CYCLES+1 cycles after accept.
// Holds the response until resp_ready; requests are refused until it is consumed.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS,
   parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
   parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dcache_req_valid_i,
   input  logic [31:0] dcache_req_addr_i,
   input  logic [31:0] dcache_req_data_i,
   input  logic        dcache_req_we_i,
   input  logic [3:0]  dcache_req_be_i,
   output logic        dcache_req_ready_o,
   output logic        dcache_resp_valid_o,
   output logic [31:0] dcache_resp_data_o,
   output logic        dcache_resp_error_o,
   input  logic        dcache_resp_ready_i
);

   localparam int                    IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [31:0]           SPAN     = 32'(4 * DEPTH_WORDS);
   localparam logic [WAIT_CNT_W-1:0] CNT_INIT = WAIT_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   dmem_state_e           state_q;
   logic [WAIT_CNT_W-1:0] cnt_q;
   logic [31:0]           addr_q;
   logic [31:0]           data_q;
   logic                  we_q;
   logic [3:0]            be_q;
   logic                  resp_valid_q;
   logic                  resp_error_q;
   logic                  resp_load_q;

   logic                  acc_go;
   logic [31:0]           acc_addr;
   logic [31:0]           acc_data;
   logic                  acc_we;
   logic [3:0]            acc_be;
   logic [31:0]           acc_off;
   logic                  acc_in_range;
   logic [IDX_W-1:0]      acc_idx;
   logic [31:0]           mem_rdata;

   // With no wait cycles the array is accessed on the accept edge, straight from the inputs.
   always_comb begin
      acc_go   = 1'b0;
      acc_addr = addr_q;
      acc_data = data_q;
      acc_we   = we_q;
      acc_be   = be_q;
      if (WAIT_CYCLES == 0) begin
         acc_go   = (state_q == ST_IDLE) && dcache_req_valid_i;
         acc_addr = dcache_req_addr_i;
         acc_data = dcache_req_data_i;
         acc_we   = dcache_req_we_i;
         acc_be   = dcache_req_be_i;
      end else begin
         acc_go   = (state_q == ST_WAIT) && (cnt_q == '0);
      end
   end

   // Unsigned offset: addresses below BASE_ADDR wrap high and fail the compare.
   assign acc_off      = acc_addr - BASE_ADDR;
   assign acc_in_range = acc_off < SPAN;
   assign acc_idx      = acc_off[IDX_W+1:2];

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk     (clk),
      .en_i    (acc_go & ~rst),
      .we_i    (acc_we & acc_in_range),
      .be_i    (acc_be),
      .idx_i   (acc_idx),
      .wdata_i (acc_data),
      .rdata_o (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         we_q         <= 1'b0;
         be_q         <= '0;
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
         resp_load_q  <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (dcache_req_valid_i) begin
                  addr_q  <= dcache_req_addr_i;
                  data_q  <= dcache_req_data_i;
                  we_q    <= dcache_req_we_i;
                  be_q    <= dcache_req_be_i;
                  cnt_q   <= CNT_INIT;
                  state_q <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  state_q <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (dcache_resp_ready_i) begin
                  state_q      <= ST_IDLE;
                  resp_valid_q <= 1'b0;
                  resp_error_q <= 1'b0;
                  resp_load_q  <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
         if (acc_go) begin
            resp_valid_q <= 1'b1;
            resp_error_q <= ~acc_in_range;
            resp_load_q  <= acc_in_range & ~acc_we;
         end
      end
   end

   assign dcache_req_ready_o  = (state_q == ST_IDLE);
   assign dcache_resp_valid_o = resp_valid_q;
   assign dcache_resp_error_o = resp_error_q;
   assign dcache_resp_data_o  = resp_load_q ? mem_rdata : 32'h0;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in the data array; power of two.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0; aligned to 4*DEPTH_WORDS.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, extra latency cycles between accept and response; range 0..15.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port dcache_req_valid_i, input, 1, request present.
REQ-007 SHALL have port dcache_req_addr_i, input, 32, byte address; bits [1:0] ignored.
REQ-008 SHALL have port dcache_req_data_i, input, 32, store data, byte lanes aligned to the word.
REQ-009 SHALL have port dcache_req_we_i, input, 1, 1 = store, 0 = load.
REQ-010 SHALL have port dcache_req_be_i, input, 4, byte enables for stores; ignored for loads.
REQ-011 SHALL have port dcache_req_ready_o, output, 1, request accepted this cycle when ANDed with valid.
REQ-012 SHALL have port dcache_resp_valid_o, output, 1, response present.
REQ-013 SHALL have port dcache_resp_data_o, output, 32, load data (full word); 0 for stores and errors.
REQ-014 SHALL have port dcache_resp_error_o, output, 1, access fault; qualified by resp_valid.
REQ-015 SHALL have port dcache_resp_ready_i, input, 1, requester consumes the response.

Function
REQ-016 SHALL implement states IDLE, WAIT and RESP; at most one request is outstanding.
REQ-017 SHALL drive dcache_req_ready_o = 1 only in IDLE.
REQ-018 On req_valid & req_ready, SHALL capture addr, data, we and be, and SHALL go to WAIT with counter = WAIT_CYCLES-1 if WAIT_CYCLES>0, else to RESP.
REQ-019 In WAIT, SHALL decrement the counter each cycle and go to RESP on the cycle the counter is 0.
REQ-020 SHALL perform the array access on the transition into RESP: a load reads the word, and a store writes only the bytes whose be bit is 1.
REQ-021 SHALL make the response appear WAIT_CYCLES+1 cycles after the accept edge: resp_valid is high in the cycle after the accept edge plus WAIT_CYCLES.
REQ-022 In RESP, SHALL hold resp_valid, resp_data and resp_error stable until resp_ready_i=1, then go to IDLE on that edge.
REQ-023 SHALL accept a new request at the earliest in the cycle after the response handshake; there is no request/response overlap.
REQ-024 SHALL flag an error when the captured address falls outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS):
  - resp_error=1 and resp_data=0;
  - a store with this error SHALL leave the array unmodified.
REQ-025 A store with be=4'b0000 SHALL be legal: no byte changes, no error.
REQ-026 SHALL return store data to a later load: a load following a store to the same word returns the merged data.
REQ-027 SHALL compute the word index as (addr - BASE_ADDR) >> 2 truncated to log2(DEPTH_WORDS) bits, only after the range check passes.
REQ-028 SHALL ignore changes on request inputs outside IDLE.

Reset
REQ-029 While rst=1, SHALL force state to IDLE, the counter to 0, and resp_valid, resp_data and resp_error to 0; req_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-030 rst asserted in WAIT or RESP SHALL discard the pending request and response:
  - a discarded store that has not yet reached RESP SHALL NOT be written;
  - a store already written SHALL remain.
REQ-031 rst SHALL NOT clear the data array; its contents are undefined after power-up.

Structure
REQ-032 dmem_pkg SHALL hold the state enum (IDLE/WAIT/RESP), default parameter constants, and the 4-bit wait-counter width.
REQ-033 The data array SHALL be a sub-module dmem_array:
  - single port, synchronous write with 4 byte-lane enables;
  - registered read;
  - inferable as SRAM.
REQ-034 The top level SHALL contain only the FSM, the capture registers, the range check and the response registers.

Verification
REQ-035 With WAIT_CYCLES=1: store addr 0x10, data 0xDEADBEEF, be 4'hF, accepted at cycle 0 -> resp_valid at cycle 2 with error 0; a following load of 0x10 returns 0xDEADBEEF.
REQ-036 Partial store, be 4'b0011, data 0x00001234, to a word holding 0xDEADBEEF -> a later load returns 0xDEAD1234.
REQ-037 Load of addr BASE_ADDR+4*DEPTH_WORDS (0x1000) -> resp_error=1, data 0; a store there leaves word 0 unchanged.
REQ-038 Hold resp_ready_i=0 for 5 cycles in RESP -> resp_valid, data and error are stable, req_ready=0 and a new request is not accepted; release -> IDLE on the next cycle.
REQ-039 Assert rst in WAIT during a store to 0x20, data 0x5A5A5A5A (old value 0x11111111) -> no response; a later load of 0x20 returns 0x11111111.
REQ-040 Run with WAIT_CYCLES=0 and WAIT_CYCLES=15, with back-to-back requests held valid -> responses land at +1 and +16 cycles after accept, in order, with no dropped or duplicated response.
